gold_nic: RTL

GOLD_NIC -- requirements
Module: gold_nic

---
 rtl/gold_pkg.sv | 26 ++
 rtl/gold_nic_buf.sv | 43 ++++
 rtl/gold_nic.sv | 103 ++++++++++
 3 files changed

// File: rtl/gold_pkg.sv
// =============================================================================
// Package     : gold_pkg
// Description : Shared packet field positions and NIC register addresses.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package gold_pkg;

    localparam int VC_BIT      = 63;
    localparam int DIR_BIT     = 62;
    localparam int HOP_MSB     = 55;
    localparam int HOP_LSB     = 48;
    localparam int SRC_MSB     = 47;
    localparam int SRC_LSB     = 32;
    localparam int PAYLOAD_MSB = 31;
    localparam int PAYLOAD_LSB = 0;

    localparam logic [1:0] ADDR_IN_DATA  = 2'd0;
    localparam logic [1:0] ADDR_IN_STAT  = 2'd1;
    localparam logic [1:0] ADDR_OUT_DATA = 2'd2;
    localparam logic [1:0] ADDR_OUT_STAT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/gold_nic_buf.sv
// =============================================================================
// Module      : gold_nic_buf
// Description : Single-entry packet register with a full flag.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module gold_nic_buf
    import gold_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    // Callers only load when empty and only clear when full, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

`default_nettype wire

// File: rtl/gold_nic.sv
// =============================================================================
// Module      : gold_nic
// Description : Processor-to-router network interface with one-entry in/out
//               buffers. Optional macro NIC_POLARITY_CHECK_EN gates injection
//               on the router polarity versus the packet VC bit.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module gold_nic
    import gold_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    input  logic                  net_polarity
);

    logic                  w_rd;
    logic                  w_wr;
    logic                  w_in_load;
    logic                  w_in_clear;
    logic                  w_in_full;
    logic [DATA_WIDTH-1:0] w_in_buf;
    logic                  w_out_load;
    logic                  w_out_full;
    logic [DATA_WIDTH-1:0] w_out_buf;
    logic                  w_inject_ok;

    assign w_rd = nicEn & ~nicWrEn;
    assign w_wr = nicEn & nicWrEn;

    assign net_ri     = ~w_in_full;
    assign w_in_load  = net_si & ~w_in_full;
    assign w_in_clear = w_rd & (addr == ADDR_WIDTH'(ADDR_IN_DATA)) & w_in_full;

    // A write while full (including the cycle that sends) is dropped.
    assign w_out_load = w_wr & (addr == ADDR_WIDTH'(ADDR_OUT_DATA)) & ~w_out_full;

`ifdef NIC_POLARITY_CHECK_EN
    assign w_inject_ok = (w_out_buf[DATA_WIDTH-1] != net_polarity);
`else
    logic w_unused_polarity;
    assign w_unused_polarity = net_polarity;
    assign w_inject_ok       = 1'b1;
`endif

    assign net_so = w_out_full & net_ro & w_inject_ok;
    assign net_do = w_out_buf;

    gold_nic_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_in_buf (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_in_load),
        .i_clear (w_in_clear),
        .i_data  (net_di),
        .o_data  (w_in_buf),
        .o_full  (w_in_full)
    );

    gold_nic_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_out_load),
        .i_clear (net_so),
        .i_data  (d_in),
        .o_data  (w_out_buf),
        .o_full  (w_out_full)
    );

    always_comb begin
        d_out = '0;
        if (w_rd) begin
            if (addr == ADDR_WIDTH'(ADDR_IN_DATA)) begin
                d_out = w_in_buf;
            end else if (addr == ADDR_WIDTH'(ADDR_IN_STAT)) begin
                d_out = {{(DATA_WIDTH-1){1'b0}}, w_in_full};
            end else if (addr == ADDR_WIDTH'(ADDR_OUT_STAT)) begin
                d_out = {{(DATA_WIDTH-1){1'b0}}, w_out_full};
            end
        end
    end

endmodule

`default_nettype wire
